// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU constants: opcode encodings, issue FSM states and latency classes.
package alu_issue_ctrl_pkg;

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_ADD   = 8'h01;
    localparam logic [7:0] ALU_SUB   = 8'h02;
    localparam logic [7:0] ALU_AND   = 8'h03;
    localparam logic [7:0] ALU_OR    = 8'h04;
    localparam logic [7:0] ALU_XOR   = 8'h05;
    localparam logic [7:0] ALU_SLL   = 8'h06;
    localparam logic [7:0] ALU_SRL   = 8'h07;
    localparam logic [7:0] ALU_MULH  = 8'h10;
    localparam logic [7:0] ALU_UMULH = 8'h11;
    localparam logic [7:0] ALU_MULL  = 8'h12;
    localparam logic [7:0] ALU_UMULL = 8'h13;
    localparam logic [7:0] ALU_FADD  = 8'h20;
    localparam logic [7:0] ALU_FSUB  = 8'h21;
    localparam logic [7:0] ALU_FMUL  = 8'h22;
    localparam logic [7:0] ALU_FCMP  = 8'h23;
    localparam logic [7:0] ALU_ITOF  = 8'h24;
    localparam logic [7:0] ALU_FTOI  = 8'h25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAT_SINGLE = 2'd0,
        LAT_MUL    = 2'd1,
        LAT_FP     = 2'd2
    } lat_class_e;

    function automatic logic is_nop(input logic [7:0] op);
        return op == ALU_NOP;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decoder-side, ALU-side and consumer-side handshake bundle of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [TAG_W-1:0]  in_tag;
    logic              alu_start;
    logic [7:0]        alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    // Controller side
    modport slave (
        input  in_valid, in_opcode, in_tag, alu_result, out_ready,
        output in_ready, alu_start, alu_opcode, out_valid, out_result, out_tag, busy
    );

    // Decoder/ALU/consumer side
    modport master (
        output in_valid, in_opcode, in_tag, alu_result, out_ready,
        input  in_ready, alu_start, alu_opcode, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/alu_issue_ctrl_lat_class.sv
// Combinational opcode to latency-class lookup; unknown encodings fall back to single-cycle.
module alu_lat_class
    import alu_issue_ctrl_pkg::*;
(
    input  logic [7:0] i_opcode,
    output lat_class_e o_lat_class
);
    always_comb begin
        o_lat_class = LAT_SINGLE;
        case (i_opcode)
            ALU_MULH, ALU_UMULH, ALU_MULL, ALU_UMULL:
                o_lat_class = LAT_MUL;
            ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FCMP, ALU_ITOF, ALU_FTOI:
                o_lat_class = LAT_FP;
            default:
                o_lat_class = LAT_SINGLE;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue sequencer: accept one op, launch it, wait its latency, hold the result.
// Optional macro ALU_ISSUE_CTRL_PERF_EN adds perf_issued/perf_stall counters.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned FP_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_ctrl_if.slave    bus
`ifdef ALU_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall
`endif
);
    localparam int unsigned MAX_LAT = (MUL_LAT > FP_LAT) ? MUL_LAT : FP_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_start;
    logic [7:0]        r_opcode;
    logic [TAG_W-1:0]  r_tag_lat;
    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [TAG_W-1:0]  r_tag;
    lat_class_e        w_class;
    logic [CNT_W-1:0]  w_lat_m1;
    logic              w_ready;
    logic              w_issue;

    alu_lat_class u_lat_class (
        .i_opcode    (bus.in_opcode),
        .o_lat_class (w_class)
    );

    always_comb begin
        w_lat_m1 = '0;
        case (w_class)
            LAT_MUL:    w_lat_m1 = CNT_W'(MUL_LAT - 1);
            LAT_FP:     w_lat_m1 = CNT_W'(FP_LAT - 1);
            default:    w_lat_m1 = '0;
        endcase
    end

    // in_ready is gated by rst_n so it stays low throughout reset
    assign w_ready = (r_state == ST_IDLE) && rst_n;
    assign w_issue = w_ready && bus.in_valid && !is_nop(bus.in_opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue)           w_next = ST_EXEC;
            ST_EXEC: if (r_cnt == '0)       w_next = ST_HOLD;
            ST_HOLD: if (bus.out_ready)     w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_opcode  <= ALU_NOP;
            r_tag_lat <= '0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
        end else begin
            r_start <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_opcode  <= bus.in_opcode;
                        r_tag_lat <= bus.in_tag;
                        r_cnt     <= w_lat_m1;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result <= bus.alu_result;
                        r_tag    <= r_tag_lat;
                        r_valid  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_valid  <= 1'b0;
                        r_opcode <= ALU_NOP;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_issue) perf_issued <= perf_issued + 32'd1;
            if (r_state == ST_HOLD && !bus.out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    assign bus.in_ready   = w_ready;
    assign bus.alu_start  = r_start;
    assign bus.alu_opcode = r_opcode;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_tag;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: timestamp-based reference model plus directed and random stimulus.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned FP_LAT  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

`ifdef ALU_ISSUE_CTRL_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    alu_issue_ctrl #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .MUL_LAT (MUL_LAT),
        .FP_LAT  (FP_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef ALU_ISSUE_CTRL_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic int unsigned lat_of(input logic [7:0] op);
        if (op inside {ALU_MULH, ALU_UMULH, ALU_MULL, ALU_UMULL}) return MUL_LAT;
        if (op inside {ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FCMP, ALU_ITOF, ALU_FTOI}) return FP_LAT;
        return 1;
    endfunction

    // Reference model: an operation accepted at edge A with latency L delivers at edge A+L
    int          n       = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    int          m_acc   = 0;
    int unsigned m_lat   = 1;
    logic [7:0]  m_op    = ALU_NOP;
    logic [3:0]  m_tagq  = '0;
    logic [31:0] m_res   = '0;
    logic [3:0]  m_tag   = '0;
    logic [31:0] m_issued = '0;
    logic [31:0] m_stall  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_op <= ALU_NOP;
            m_res <= '0; m_tag <= '0; m_issued <= '0; m_stall <= '0;
        end else begin
            n <= n + 1;
            if (!m_busy) begin
                if (bus.in_valid && bus.in_opcode != ALU_NOP) begin
                    m_busy <= 1'b1; m_done <= 1'b0; m_acc <= n + 1;
                    m_lat <= lat_of(bus.in_opcode); m_op <= bus.in_opcode; m_tagq <= bus.in_tag;
                    m_issued <= m_issued + 1;
                end
            end else if (!m_done) begin
                if (n + 1 == m_acc + int'(m_lat)) begin
                    m_done <= 1'b1; m_res <= bus.alu_result; m_tag <= m_tagq;
                end
            end else if (bus.out_ready) begin
                m_busy <= 1'b0; m_done <= 1'b0; m_op <= ALU_NOP;
            end else begin
                m_stall <= m_stall + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready",   32'(bus.in_ready),   32'(!m_busy && rst_n));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("alu_start",  32'(bus.alu_start),  32'(m_busy && !m_done && n == m_acc));
        check("alu_opcode", 32'(bus.alu_opcode), 32'(m_op));
        check("out_valid",  32'(bus.out_valid),  32'(m_busy && m_done));
        check("out_result", bus.out_result,      m_res);
        check("out_tag",    32'(bus.out_tag),    32'(m_tag));
`ifdef ALU_ISSUE_CTRL_PERF_EN
        check("perf_issued", perf_issued, m_issued);
        check("perf_stall",  perf_stall,  m_stall);
`endif
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] ops [20] = '{ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                             ALU_SRL, ALU_MULH, ALU_UMULH, ALU_MULL, ALU_UMULL, ALU_FADD,
                             ALU_FSUB, ALU_FMUL, ALU_FCMP, ALU_ITOF, ALU_FTOI, 8'hFF, 8'h40};

    initial begin
        int first;
        int bcnt;
        int starts;
        logic [31:0] rsave;

        bus.in_valid = 1'b0; bus.in_opcode = ALU_NOP; bus.in_tag = '0;
        bus.alu_result = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_alu_opcode", 32'(bus.alu_opcode), 32'(ALU_NOP));

        // ADD, single cycle
        bus.in_valid = 1'b1; bus.in_opcode = ALU_ADD; bus.in_tag = 4'h3;
        bus.alu_result = 32'h0000_0005; bus.out_ready = 1'b1;
        cyc();
        check("add_start", 32'(bus.alu_start), 32'd1);
        check("add_in_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        cyc();
        check("add_out_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", bus.out_result, 32'd5);
        check("add_tag", 32'(bus.out_tag), 32'h3);
        check("add_start_once", 32'(bus.alu_start), 32'd0);
        cyc();
        check("add_release", 32'(bus.in_ready), 32'd1);

        // MULL, latency 3
        bus.in_valid = 1'b1; bus.in_opcode = ALU_MULL; bus.in_tag = 4'h5;
        bus.alu_result = 32'h0001_0000;
        first = -1; bcnt = 0; rsave = '0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) bus.in_valid = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.out_valid && first < 0) begin first = k; rsave = bus.out_result; end
        end
        check("mul_latency", 32'(first), 32'd3);
        check("mul_busy_cycles", 32'(bcnt), 32'd4);
        check("mul_result", rsave, 32'h0001_0000);

        // FADD, consumer stalls 5 cycles
        bus.in_valid = 1'b1; bus.in_opcode = ALU_FADD; bus.in_tag = 4'h9;
        bus.alu_result = 32'hDEAD_BEEF; bus.out_ready = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        bus.alu_result = 32'h1111_2222;
        cyc();
        check("fp_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.alu_result = $urandom;
            cyc();
            check("fp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("fp_hold_result", bus.out_result, 32'h1111_2222);
        end
`ifdef ALU_ISSUE_CTRL_PERF_EN
        check("fp_perf_stall", perf_stall, 32'd5);
`endif
        bus.out_ready = 1'b1;
        cyc();
        check("fp_release", 32'(bus.in_ready), 32'd1);

        // NOP stream is discarded
        bus.in_valid = 1'b1; bus.in_opcode = ALU_NOP;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("nop_in_ready", 32'(bus.in_ready), 32'd1);
            check("nop_start", 32'(bus.alu_start), 32'd0);
            check("nop_out_valid", 32'(bus.out_valid), 32'd0);
        end
`ifdef ALU_ISSUE_CTRL_PERF_EN
        check("nop_perf_issued", perf_issued, 32'd3);
`endif

        // Reset during FMUL execution
        bus.in_opcode = ALU_FMUL; bus.in_tag = 4'h2; bus.alu_result = 32'h5555_5555;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("rst_no_result", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b1; bus.in_opcode = ALU_SUB; bus.in_tag = 4'h7; bus.alu_result = 32'h0000_1234;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        check("sub_out_valid", 32'(bus.out_valid), 32'd1);
        check("sub_result", bus.out_result, 32'h0000_1234);
        check("sub_tag", 32'(bus.out_tag), 32'h7);
        cyc();

        // in_valid held with changing opcode while busy
        bus.in_valid = 1'b1; bus.in_opcode = ALU_MULH; bus.in_tag = 4'h1;
        bus.alu_result = 32'h0000_AAAA; bus.out_ready = 1'b0;
        cyc();
        starts = int'(bus.alu_start);
        for (int k = 1; k <= 3; k++) begin
            bus.in_opcode = ops[1 + ($urandom % 19)];
            cyc();
            starts += int'(bus.alu_start);
            check("hold_opcode", 32'(bus.alu_opcode), 32'(ALU_MULH));
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("hold_tag", 32'(bus.out_tag), 32'h1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            starts += int'(bus.alu_start);
            check("hold_idle", 32'(bus.busy), 32'd0);
        end
        check("hold_single_start", 32'(starts), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid   = ($urandom % 3) != 0;
            bus.in_opcode  = ops[$urandom % 20];
            bus.in_tag     = 4'($urandom);
            bus.alu_result = $urandom;
            bus.out_ready  = ($urandom % 4) != 0;
            rst_n          = ($urandom % 150) != 0;
            cyc();
        end
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (10) cyc();
        check("drain_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer between the instruction decoder and the ALU datapath.
- Accepts one decoded ALU operation per valid/ready handshake and launches it on the ALU.
- Waits out the opcode's latency class (single-cycle, multiplier, floating-point), captures the result, and holds it until the consumer accepts it.
- Only one operation is in flight at a time; the controller is the sole owner of the ALU start strobe.

Parameters:
- DATA_W, 32, ALU result width.
- TAG_W, 4, width of the destination/transaction tag carried alongside each operation.
- MUL_LAT, 3, cycles for MULH/UMULH/MULL/UMULL; must be >= 1.
- FP_LAT, 4, cycles for FADD/FSUB/FMUL/FCMP/ITOF/FTOI; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded operation available.
- in_ready  out  1  controller can accept an operation.
- in_opcode  in  8  ALU opcode, encoded per the shared ALU constants header.
- in_tag  in  TAG_W  tag returned with the result.
- alu_start  out  1  one-cycle launch strobe to the ALU.
- alu_opcode  out  8  opcode presented to the ALU; held stable for the whole operation.
- alu_result  in  DATA_W  ALU result; valid when the latency count expires.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  captured result.
- out_tag  out  TAG_W  tag of the captured result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, counter = 0.
  - alu_start = 0, alu_opcode = ALU_NOP, out_valid = 0, out_result = 0, out_tag = 0.
  - in_ready is low while rst_n is low and becomes high in IDLE once reset is released.
- Latency class, decoded combinationally from in_opcode:
  - MUL (MULH, UMULH, MULL, UMULL) uses MUL_LAT.
  - FP (FADD, FSUB, FMUL, FCMP, ITOF, FTOI) uses FP_LAT.
  - Every other non-NOP opcode uses 1. Unknown encodings are treated as 1.
- Handshake:
  - in_ready = (state == IDLE).
  - Acceptance occurs on a rising edge where in_valid && in_ready.
  - out_valid and out_result/out_tag stay stable until an edge with out_ready high.
- States:
  - IDLE:
    - On acceptance of ALU_NOP: the operation is consumed and discarded. No alu_start, no output, state stays IDLE.
    - On acceptance of any other opcode: latch opcode to alu_opcode and latch tag; counter = LAT-1; alu_start = 1 for the next cycle only; go to EXEC.
  - EXEC:
    - alu_start = 0 after its first cycle.
    - Each edge with counter != 0: counter decrements.
    - Edge with counter == 0: out_result = alu_result, out_tag = latched tag, out_valid = 1; go to HOLD.
  - HOLD:
    - Edge with out_ready high: out_valid = 0, alu_opcode = ALU_NOP; go to IDLE.
    - out_ready low: stay in HOLD with all outputs frozen.
- Timing:
  - If accepted at edge T, out_valid rises at edge T+LAT.
  - Minimum issue interval is LAT+2 cycles, since in_ready is low in EXEC and HOLD.
- Boundary conditions:
  - in_valid held high in EXEC/HOLD has no effect.
  - out_ready high while out_valid is low is ignored.
  - out_ready high on the same edge HOLD is entered is not seen. Acceptance needs out_valid already high.
  - Reset asserted mid-EXEC or mid-HOLD drops the pending result, with no partial output.
  - LAT = 1 gives EXEC exactly one cycle.

Optional Feature:
- Macro: ALU_ISSUE_CTRL_PERF_EN.
- When defined, adds two outputs, both cleared by reset and wrapping modulo 2^32:
  - perf_issued (32): increments on each non-NOP acceptance.
  - perf_stall (32): increments on each cycle in HOLD with out_ready low.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared ALU constants header additions:
  - State encodings ST_IDLE/ST_EXEC/ST_HOLD (2 bits).
  - Latency class codes LAT_SINGLE/LAT_MUL/LAT_FP.
  - Existing ALU opcode macros are reused unchanged.
- One natural sub-module: alu_lat_class, a combinational opcode to latency-class lookup, reusable by the hazard logic.

Test Plan:
- ALU_ADD, tag 4'h3, alu_result=32'h0000_0005, out_ready=1 -> alu_start pulses exactly 1 cycle; out_valid rises 1 edge after acceptance with out_result=5, out_tag=3; in_ready returns high 1 cycle later.
- ALU_MULL with MUL_LAT=3, result 32'h0001_0000 -> out_valid rises 3 edges after acceptance; busy high for 4 cycles total.
- ALU_FADD with FP_LAT=4, out_ready held low 5 cycles -> out_valid and out_result stable for all 5 cycles, perf_stall=5 (macro defined); release out_ready -> IDLE next edge.
- ALU_NOP with in_valid high for 3 cycles -> in_ready stays high, alu_start never asserts, out_valid stays 0, perf_issued=0.
- rst_n pulsed low during EXEC of ALU_FMUL -> out_valid=0, busy=0 immediately, no result ever emitted; a following ALU_SUB completes normally.
- in_valid held high with changing in_opcode during EXEC -> the latched alu_opcode is unchanged and only the first operation completes.
